// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and size decode for the data-memory controller
package dmem_pkg;

    localparam int DMEM_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HWRD,
        SZ_WORD
    } dmem_size_t;

    // Byte wins over halfword, halfword over word; no size flag means word.
    function automatic dmem_size_t size_decode(input logic is_byte,
                                               input logic is_hwrd,
                                               input logic is_wrd);
        if (is_byte)
            return SZ_BYTE;
        else if (is_hwrd)
            return SZ_HWRD;
        else if (is_wrd)
            return SZ_WORD;
        else
            return SZ_WORD;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - word-addressed system data bus between the controller and memory
interface dmem_if;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-enable, misalignment, store replication and load extension
module dmem_align
    import dmem_pkg::*;
(
    input  dmem_size_t  size,
    input  logic [1:0]  addr_lo,
    input  logic        rdu,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic        misalign,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        lane      = bus_rdata >> {addr_lo, 3'b000};
        be        = 4'b1111;
        misalign  = 1'b0;
        wdata_rep = wdata;
        rdata_ext = lane;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~rdu & lane[7]}}, lane[7:0]};
            end
            SZ_HWRD: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign  = addr_lo[0];
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~rdu & lane[15]}}, lane[15:0]};
            end
            default: begin
                be        = 4'b1111;
                misalign  = |addr_lo;
                wdata_rep = wdata;
                rdata_ext = lane;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - FSM turning sized byte-addressed accesses into word bus transactions
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_write,
    input  logic        dmem_read,
    input  logic        dmem_rdu,
    input  logic        dmem_byte,
    input  logic        dmem_hwrd,
    input  logic        dmem_wrd,
    output logic        dmem_drdy,
    output logic [31:0] dmem_rdata,
    output logic        dmem_misalign,
    output logic        dmem_err,
    dmem_if.master      bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    dmem_state_t state;
    logic [CW-1:0] cnt;
    logic [3:0]  be_c;
    logic        misalign_c;
    logic [31:0] wdata_c;
    logic [31:0] rdata_c;
    logic        pending;

    assign pending = dmem_read | dmem_write;

    // Inputs are held stable by mem until drdy, so the live address and size
    // are still valid when the read word returns.
    dmem_align u_align (
        .size      (size_decode(dmem_byte, dmem_hwrd, dmem_wrd)),
        .addr_lo   (dmem_addr[1:0]),
        .rdu       (dmem_rdu),
        .wdata     (dmem_wdata),
        .bus_rdata (bus.bus_rdata),
        .be        (be_c),
        .misalign  (misalign_c),
        .wdata_rep (wdata_c),
        .rdata_ext (rdata_c)
    );

    assign dmem_drdy = (state == ST_DONE) || (state == ST_IDLE && !pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            dmem_rdata    <= '0;
            dmem_misalign <= 1'b0;
            dmem_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        if (misalign_c) begin
                            dmem_misalign <= 1'b1;
                            dmem_rdata    <= '0;
                            state         <= ST_DONE;
                        end else begin
                            bus.bus_addr  <= dmem_addr[31:2];
                            bus.bus_be    <= be_c;
                            bus.bus_we    <= dmem_write;
                            bus.bus_wdata <= wdata_c;
                            bus.bus_req   <= 1'b1;
                            cnt           <= '0;
                            state         <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        dmem_rdata  <= bus.bus_we ? 32'h0 : rdata_c;
                        state       <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus.bus_req <= 1'b0;
                        dmem_err    <= 1'b1;
                        dmem_rdata  <= '0;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    dmem_misalign <= 1'b0;
                    dmem_err      <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_write;
    logic        dmem_read;
    logic        dmem_rdu;
    logic        dmem_byte;
    logic        dmem_hwrd;
    logic        dmem_wrd;
    logic        dmem_drdy;
    logic [31:0] dmem_rdata;
    logic        dmem_misalign;
    logic        dmem_err;

    int n_pass  = 0;
    int n_total = 0;

    dmem_if bus_if ();

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_write    (dmem_write),
        .dmem_read     (dmem_read),
        .dmem_rdu      (dmem_rdu),
        .dmem_byte     (dmem_byte),
        .dmem_hwrd     (dmem_hwrd),
        .dmem_wrd      (dmem_wrd),
        .dmem_drdy     (dmem_drdy),
        .dmem_rdata    (dmem_rdata),
        .dmem_misalign (dmem_misalign),
        .dmem_err      (dmem_err),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic b, input logic h,
                         input logic w, input logic u);
        dmem_read  = rd;
        dmem_write = wr;
        dmem_addr  = addr;
        dmem_wdata = wd;
        dmem_byte  = b;
        dmem_hwrd  = h;
        dmem_wrd   = w;
        dmem_rdu   = u;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        idle();
        tick();
        tick();
        chk("rst_req",      bus_if.bus_req,   0);
        chk("rst_we",       bus_if.bus_we,    0);
        chk("rst_be",       bus_if.bus_be,    0);
        chk("rst_addr",     bus_if.bus_addr,  0);
        chk("rst_wdata",    bus_if.bus_wdata, 0);
        chk("rst_rdata",    dmem_rdata,       0);
        chk("rst_misalign", dmem_misalign,    0);
        chk("rst_err",      dmem_err,         0);
        chk("rst_drdy",     dmem_drdy,        1);
        rst = 1'b0;
        tick();

        // lb 0x1003, zero-wait ack
        drive(1'b1, 1'b0, 32'h1003, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lb_c0_drdy", dmem_drdy, 0);
        tick();
        chk("lb_c1_req",  bus_if.bus_req,  1);
        chk("lb_c1_addr", bus_if.bus_addr, 32'h400);
        chk("lb_c1_be",   bus_if.bus_be,   4'b1000);
        chk("lb_c1_we",   bus_if.bus_we,   0);
        chk("lb_c1_drdy", dmem_drdy,       0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h80FF_1234;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("lb_c2_drdy",  dmem_drdy,      1);
        chk("lb_c2_rdata", dmem_rdata,     32'hFFFF_FF80);
        chk("lb_c2_req",   bus_if.bus_req, 0);
        idle();
        tick();
        chk("lb_c3_drdy", dmem_drdy, 1);

        // lhu 0x2002, ack after 3 waits
        drive(1'b1, 1'b0, 32'h2002, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("lhu_c1_be",  bus_if.bus_be,  4'b1100);
        chk("lhu_c1_req", bus_if.bus_req, 1);
        tick();
        tick();
        chk("lhu_c3_req",  bus_if.bus_req, 1);
        chk("lhu_c3_drdy", dmem_drdy,      0);
        tick();
        chk("lhu_c4_drdy", dmem_drdy, 0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hBEEF_0000;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("lhu_c5_drdy",  dmem_drdy,  1);
        chk("lhu_c5_rdata", dmem_rdata, 32'h0000_BEEF);
        idle();
        tick();

        // lw 0x5000, ack never arrives (TIMEOUT=4)
        drive(1'b1, 1'b0, 32'h5000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("to_c1_req", bus_if.bus_req, 1);
        tick();
        tick();
        tick();
        chk("to_c4_req",  bus_if.bus_req, 1);
        chk("to_c4_err",  dmem_err,       0);
        chk("to_c4_drdy", dmem_drdy,      0);
        tick();
        chk("to_c5_err",   dmem_err,       1);
        chk("to_c5_rdata", dmem_rdata,     0);
        chk("to_c5_drdy",  dmem_drdy,      1);
        chk("to_c5_req",   bus_if.bus_req, 0);
        idle();
        tick();
        chk("to_c6_err", dmem_err,       0);
        chk("to_c6_req", bus_if.bus_req, 0);

        // sb 0xA5 to 0x3001, one wait
        drive(1'b0, 1'b1, 32'h3001, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sb_c1_we",    bus_if.bus_we,    1);
        chk("sb_c1_be",    bus_if.bus_be,    4'b0010);
        chk("sb_c1_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
        chk("sb_c1_addr",  bus_if.bus_addr,  32'hC00);
        tick();
        chk("sb_c2_req", bus_if.bus_req, 1);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("sb_c3_drdy",  dmem_drdy,      1);
        chk("sb_c3_rdata", dmem_rdata,     0);
        chk("sb_c3_req",   bus_if.bus_req, 0);
        idle();
        tick();

        // misaligned lw 0x4002
        drive(1'b1, 1'b0, 32'h4002, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mis_c0_drdy", dmem_drdy, 0);
        tick();
        chk("mis_c1_req",      bus_if.bus_req, 0);
        chk("mis_c1_misalign", dmem_misalign,  1);
        chk("mis_c1_drdy",     dmem_drdy,      1);
        idle();
        tick();
        chk("mis_c2_misalign", dmem_misalign,  0);
        chk("mis_c2_req",      bus_if.bus_req, 0);

        // reset in the second BUSY cycle, then a late ack
        drive(1'b1, 1'b0, 32'h6000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rmo_c1_req", bus_if.bus_req, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rmo_c3_req", bus_if.bus_req, 0);
        rst = 1'b0;
        idle();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("rmo_c4_rdata",    dmem_rdata,     0);
        chk("rmo_c4_err",      dmem_err,       0);
        chk("rmo_c4_misalign", dmem_misalign,  0);
        chk("rmo_c4_req",      bus_if.bus_req, 0);
        tick();
        chk("rmo_c5_rdata", dmem_rdata, 0);

        // lbu 0x6001 after the reset proceeds normally
        drive(1'b1, 1'b0, 32'h6001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lbu_c1_be",  bus_if.bus_be,   4'b0010);
        chk("lbu_c1_req", bus_if.bus_req,  1);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h0000_9A00;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("lbu_c2_drdy",  dmem_drdy,  1);
        chk("lbu_c2_rdata", dmem_rdata, 32'h0000_009A);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
